text_term_ctrl: RTL and testbench
=================================

// Module: text_term_ctrl
// PURPOSE
// - Terminal controller for the 100x30 8x16 text display: consumes an ASCII byte stream (UART/CPU), writes VRAM, keeps the cursor.
// - Drives the VRAM write port, plus the cursor_x / cursor_y / cursor_blink inputs of the text renderer.
// - Handles control codes (CR, LF, BS, FF), auto line wrap, row clear and screen clear.
// PARAMETERS
// - COLS       100       characters per row
// - ROWS       30        rows per screen
// - BLINK_DIV  25000000  clk cycles per cursor_blink half-period (0.5 s at 50 MHz)
// PORTS
// - clk           in   1   system clock; all logic on rising edge
// - rst_n         in   1   asynchronous active-low reset
// - char_valid    in   1   char_data valid
// - char_data     in   8   ASCII byte
// - char_ready    out  1   controller accepts; transfer on char_valid & char_ready
// - vram_we       out  1   VRAM write strobe, one cell per cycle
// - vram_waddr    out  12  cell address = row*COLS + col
// - vram_wdata    out  8   ASCII written
// - cursor_x      out  7   cursor column, 0..COLS-1
// - cursor_y      out  5   cursor row, 0..ROWS-1
// - cursor_blink  out  1   1 = draw cursor (inverse video)
// - busy          out  1   high in any clear state
// BEHAVIOUR
// - Reset values: char_ready=0, vram_we=0, vram_waddr=0, vram_wdata=0, cursor_x=0, cursor_y=0, cursor_blink=1, busy=1, blink counter=0.
// - State after reset: CLR_SCR.
// - States:
//   - IDLE: char_ready=1.
//   - PUT: one write at the cursor.
//   - CLR_LINE: COLS writes of 0x20 to row cursor_y, cols 0..COLS-1.
//   - CLR_SCR: COLS*ROWS writes of 0x20, addr 0..2999 ascending.
//   - Every state except IDLE -> IDLE when done.
// - char_ready=1 only in IDLE; one byte accepted per IDLE visit.
//   - Registered: the cycle after acceptance, char_ready=0.
// - Printable byte 0x20..0x7E:
//   - PUT writes (cursor_y*COLS+cursor_x, byte); vram_we is high the cycle after acceptance.
//   - Same edge, cursor advances: x+1.
//   - If x==COLS-1: x=0, y=y+1 (ROWS-1 wraps to 0), then CLR_LINE on the new row.
// - 0x0D CR: x=0; no write; back to IDLE next cycle.
// - 0x0A LF: x=0, y=y+1 (ROWS-1 -> 0), then CLR_LINE. There is no scrolling; output wraps to the top.
// - 0x08 BS:
//   - If x>0: x=x-1 and write 0x20 at the new position.
//   - If x==0: no-op, even on row 0; no reverse line wrap.
// - 0x0C FF: x=0, y=0, then CLR_SCR.
// - Any other byte: accepted and discarded, with no state or VRAM change.
// - Address is computed from registered cursor values: mult-by-constant, 12-bit result, max 2999.
// - cursor_x/cursor_y update on the same edge vram_we asserts for PUT/BS. Renderer sees the new position the next cycle.
// - Blink counter:
//   - Counts 0..BLINK_DIV-1; on terminal count, cursor_blink toggles and the counter returns to 0.
//   - Any cursor change forces cursor_blink=1 and counter=0, so the cursor stays solid while typing.
// - busy = (state==CLR_LINE || state==CLR_SCR).
// - char_valid held during a clear: the byte waits, no loss, and is accepted on the first IDLE cycle.
// - rst_n asserted mid-clear or mid-PUT: immediate return to reset values; the full CLR_SCR restarts after release.
// STRUCTURE
// - Package text_term_pkg holds:
//   - ASCII_CR=8'h0D, ASCII_LF=8'h0A, ASCII_BS=8'h08, ASCII_FF=8'h0C, ASCII_SP=8'h20;
//   - TXT_COLS=100, TXT_ROWS=30, VRAM_AW=12;
//   - a 3-bit state encoding for IDLE, PUT, CLR_LINE, CLR_SCR.
// - Sub-module cursor_blink_gen (BLINK_DIV; ports clk, rst_n, restart, blink).
// - Clear counter is a single 12-bit down-counter shared by CLR_LINE and CLR_SCR.
// TESTING (sim with BLINK_DIV=16)
// - Reset release -> busy=1 and exactly 3000 writes of 0x20, addr 0..2999 in order, on consecutive cycles.
//   - Then char_ready=1, cursor (0,0).
// - After idle, send 'A'(0x41) then 'B' ->
//   - writes (0,0x41) then (1,0x42);
//   - cursor_x=2, cursor_y=0.
// - Cursor at (99,0), send 'Z' ->
//   - write (99,0x5A);
//   - cursor (0,1);
//   - 100 writes 0x20 at addr 100..199;
//   - busy low after.
// - Cursor (5,29), send 0x0A -> cursor (0,0); clear writes addr 0..99; no write to row 29.
// - BS at (3,2) -> write (202,0x20), cursor (2,2). BS at (0,2) -> no write, cursor unchanged.
// - Idle 64 cycles -> cursor_blink toggles every 16 cycles.
//   - Send 'x' mid-period: cursor_blink=1 and holds 16 cycles.
// - Assert rst_n during CLR_LINE (char_valid held high) -> outputs at reset values immediately.
//   - Full 3000-write clear restarts after release.
//   - The pending byte is then accepted.

Source files
------------

// File: rtl/text_term_pkg.sv
// Shared constants for the 100x30 text terminal: control codes, geometry,
// controller state encoding and the VRAM cell address helper.
package text_term_pkg;

   localparam logic [7:0] ASCII_BS    = 8'h08;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_FF    = 8'h0C;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_SP    = 8'h20;
   localparam logic [7:0] ASCII_TILDE = 8'h7E;

   localparam int TXT_COLS = 100;
   localparam int TXT_ROWS = 30;
   localparam int VRAM_AW  = 12;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_PUT      = 3'd1;
   localparam logic [2:0] ST_CLR_LINE = 3'd2;
   localparam logic [2:0] ST_CLR_SCR  = 3'd3;

   // Clear that must follow the current PUT cycle.
   typedef enum logic [1:0] {
      CLR_NONE = 2'd0,
      CLR_ROW  = 2'd1,
      CLR_ALL  = 2'd2
   } clr_req_t;

   function automatic logic [VRAM_AW-1:0] cell_addr(input logic [4:0] row,
                                                    input logic [6:0] col,
                                                    input int cols);
      return VRAM_AW'(row) * VRAM_AW'(cols) + VRAM_AW'(col);
   endfunction

endpackage

// File: rtl/cursor_blink_gen.sv
// Cursor blink generator: toggles blink every BLINK_DIV cycles; restart forces
// the cursor solid and restarts the half-period.
module cursor_blink_gen #(
   parameter int BLINK_DIV = 25000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   output logic blink
);

   localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   logic [CW-1:0] cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
         blink   <= 1'b1;
      end else if (restart) begin
         cnt_reg <= '0;
         blink   <= 1'b1;
      end else if (cnt_reg == CW'(BLINK_DIV - 1)) begin
         cnt_reg <= '0;
         blink   <= ~blink;
      end else begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

endmodule

// File: rtl/text_term_ctrl.sv
// Text terminal controller: accepts an ASCII stream, writes VRAM cells,
// tracks the cursor and performs row/screen clears.
module text_term_ctrl
   import text_term_pkg::*;
#(
   parameter int COLS      = TXT_COLS,
   parameter int ROWS      = TXT_ROWS,
   parameter int BLINK_DIV = 25000000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               char_valid,
   input  logic [7:0]         char_data,
   output logic               char_ready,
   output logic               vram_we,
   output logic [VRAM_AW-1:0] vram_waddr,
   output logic [7:0]         vram_wdata,
   output logic [6:0]         cursor_x,
   output logic [4:0]         cursor_y,
   output logic               cursor_blink,
   output logic               busy
);

   localparam logic [VRAM_AW-1:0] SCR_LAST = VRAM_AW'(COLS * ROWS - 1);

   logic [2:0]         state_reg;
   clr_req_t           clr_req_reg;
   logic [VRAM_AW-1:0] clr_cnt_reg;
   logic [VRAM_AW-1:0] clr_last_reg;

   logic               accept;
   logic [VRAM_AW-1:0] cur_addr;
   logic [4:0]         y_inc;
   logic [6:0]         x_next;
   logic [4:0]         y_next;
   logic               put_we;
   logic [VRAM_AW-1:0] put_addr;
   logic [7:0]         put_data;
   clr_req_t           req_next;
   logic               cursor_moved;

   assign char_ready = (state_reg == ST_IDLE);
   assign busy       = (state_reg == ST_CLR_LINE) || (state_reg == ST_CLR_SCR);
   assign accept     = char_valid && char_ready;
   assign cur_addr   = cell_addr(cursor_y, cursor_x, COLS);
   assign y_inc      = (cursor_y == 5'(ROWS - 1)) ? 5'd0 : cursor_y + 5'd1;

   always_comb begin
      x_next   = cursor_x;
      y_next   = cursor_y;
      put_we   = 1'b0;
      put_addr = cur_addr;
      put_data = char_data;
      req_next = CLR_NONE;
      if (accept) begin
         if (char_data >= ASCII_SP && char_data <= ASCII_TILDE) begin
            put_we = 1'b1;
            if (cursor_x == 7'(COLS - 1)) begin
               x_next   = 7'd0;
               y_next   = y_inc;
               req_next = CLR_ROW;
            end else begin
               x_next = cursor_x + 7'd1;
            end
         end else begin
            case (char_data)
               ASCII_CR: x_next = 7'd0;
               ASCII_LF: begin
                  x_next   = 7'd0;
                  y_next   = y_inc;
                  req_next = CLR_ROW;
               end
               // Backspace stops at column 0; it never wraps to the previous row.
               ASCII_BS: if (cursor_x != 7'd0) begin
                  x_next   = cursor_x - 7'd1;
                  put_we   = 1'b1;
                  put_addr = cur_addr - VRAM_AW'(1);
                  put_data = ASCII_SP;
               end
               ASCII_FF: begin
                  x_next   = 7'd0;
                  y_next   = 5'd0;
                  req_next = CLR_ALL;
               end
               default: ;
            endcase
         end
      end
   end

   assign cursor_moved = (x_next != cursor_x) || (y_next != cursor_y);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ST_CLR_SCR;
         clr_req_reg  <= CLR_NONE;
         clr_cnt_reg  <= SCR_LAST;
         clr_last_reg <= SCR_LAST;
         cursor_x     <= 7'd0;
         cursor_y     <= 5'd0;
         vram_we      <= 1'b0;
         vram_waddr   <= '0;
         vram_wdata   <= 8'd0;
      end else begin
         vram_we <= 1'b0;
         case (state_reg)
            ST_IDLE: if (accept) begin
               state_reg   <= ST_PUT;
               clr_req_reg <= req_next;
               cursor_x    <= x_next;
               cursor_y    <= y_next;
               vram_we     <= put_we;
               if (put_we) begin
                  vram_waddr <= put_addr;
                  vram_wdata <= put_data;
               end
            end
            // cursor_y already holds the new row here, so the row span is taken from it.
            ST_PUT: begin
               clr_req_reg <= CLR_NONE;
               case (clr_req_reg)
                  CLR_ROW: begin
                     state_reg    <= ST_CLR_LINE;
                     clr_cnt_reg  <= VRAM_AW'(COLS - 1);
                     clr_last_reg <= cell_addr(cursor_y, 7'(COLS - 1), COLS);
                  end
                  CLR_ALL: begin
                     state_reg    <= ST_CLR_SCR;
                     clr_cnt_reg  <= SCR_LAST;
                     clr_last_reg <= SCR_LAST;
                  end
                  default: state_reg <= ST_IDLE;
               endcase
            end
            // Down-counter runs to zero while the address ascends to clr_last_reg.
            ST_CLR_LINE, ST_CLR_SCR: begin
               vram_we    <= 1'b1;
               vram_waddr <= clr_last_reg - clr_cnt_reg;
               vram_wdata <= ASCII_SP;
               if (clr_cnt_reg == '0) begin
                  state_reg <= ST_IDLE;
               end else begin
                  clr_cnt_reg <= clr_cnt_reg - VRAM_AW'(1);
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   cursor_blink_gen #(
      .BLINK_DIV (BLINK_DIV)
   ) u_blink (
      .clk     (clk),
      .rst_n   (rst_n),
      .restart (cursor_moved),
      .blink   (cursor_blink)
   );

endmodule

// File: tb/tb_text_term_ctrl.sv
// Directed bench for text_term_ctrl: every VRAM write is logged with its cycle
// number, and each scenario task checks the log and cursor against hand values.
`timescale 1ns/100ps
module tb_text_term_ctrl;

   logic        clk;
   logic        rst_n;
   logic        char_valid;
   logic [7:0]  char_data;
   logic        char_ready;
   logic        vram_we;
   logic [11:0] vram_waddr;
   logic [7:0]  vram_wdata;
   logic [6:0]  cursor_x;
   logic [4:0]  cursor_y;
   logic        cursor_blink;
   logic        busy;

   int errors = 0;
   int checks = 0;
   logic [31:0] cyc = 0;

   typedef struct packed {
      logic [11:0] addr;
      logic [7:0]  data;
      logic [31:0] cyc;
   } wr_t;
   wr_t wlog[$];

   text_term_ctrl #(.BLINK_DIV(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .char_valid   (char_valid),
      .char_data    (char_data),
      .char_ready   (char_ready),
      .vram_we      (vram_we),
      .vram_waddr   (vram_waddr),
      .vram_wdata   (vram_wdata),
      .cursor_x     (cursor_x),
      .cursor_y     (cursor_y),
      .cursor_blink (cursor_blink),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always begin
      @(posedge clk);
      #1;
      if (vram_we === 1'b1) wlog.push_back('{vram_waddr, vram_wdata, cyc});
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_ready(input int limit);
      int n = 0;
      while (char_ready !== 1'b1 && n < limit) begin
         step();
         n++;
      end
      if (char_ready !== 1'b1) begin
         errors++;
         checks++;
         $display("FAIL wait_ready: char_ready=%b after %0d cycles, required 1", char_ready, n);
      end
   endtask

   task automatic send(input logic [7:0] b);
      wait_ready(4000);
      char_valid = 1'b1;
      char_data  = b;
      step();
      char_valid = 1'b0;
   endtask

   task automatic check_reset_outputs(input string name);
      logic [35:0] got, exp;
      got = {char_ready, vram_we, vram_waddr, vram_wdata, cursor_x, cursor_y, cursor_blink, busy};
      exp = {1'b0, 1'b0, 12'd0, 8'd0, 7'd0, 5'd0, 1'b1, 1'b1};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: outputs=%h, required %h", name, got, exp);
      end
   endtask

   task automatic check_full_clear(input string name);
      int bad = 0;
      checks++;
      if (wlog.size() != 3000) bad++;
      foreach (wlog[i]) begin
         if (wlog[i].addr !== 12'(i) || wlog[i].data !== 8'h20 ||
             wlog[i].cyc !== wlog[0].cyc + 32'(i)) bad++;
      end
      if (bad != 0) begin
         errors++;
         $display("FAIL %s: %0d writes with %0d bad entries, required 3000 ascending 0x20 writes", name, wlog.size(), bad);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      char_valid = 1'b0;
      char_data = 8'h00;
      repeat (3) step();
      check_reset_outputs("reset_values");
      wlog.delete();
      rst_n = 1'b1;
      wait_ready(4000);
      check_full_clear("reset_clear_screen");
      checks++;
      if ({char_ready, busy, cursor_x, cursor_y} !== {1'b1, 1'b0, 7'd0, 5'd0}) begin
         errors++;
         $display("FAIL post_reset_idle: ready=%b busy=%b x=%0d y=%0d, required 1 0 0 0", char_ready, busy, cursor_x, cursor_y);
      end
      $display("reset: %0d clear writes, cursor (%0d,%0d)", wlog.size(), cursor_x, cursor_y);
   endtask

   task automatic test_put_ab();
      wlog.delete();
      send(8'h41);
      checks++;
      if (char_ready !== 1'b0) begin
         errors++;
         $display("FAIL ready_drop: char_ready=%b after accept, required 0", char_ready);
      end
      send(8'h42);
      checks++;
      if (wlog.size() != 2 || wlog[0].addr !== 12'd0 || wlog[0].data !== 8'h41 ||
          wlog[1].addr !== 12'd1 || wlog[1].data !== 8'h42) begin
         errors++;
         $display("FAIL put_ab_writes: %0d writes first=(%0d,%h), required (0,41) then (1,42)", wlog.size(),
                  (wlog.size() > 0) ? wlog[0].addr : 12'hfff, (wlog.size() > 0) ? wlog[0].data : 8'hff);
      end
      checks++;
      if (cursor_x !== 7'd2 || cursor_y !== 5'd0) begin
         errors++;
         $display("FAIL put_ab_cursor: (%0d,%0d), required (2,0)", cursor_x, cursor_y);
      end
      $display("put A,B: %0d writes, cursor (%0d,%0d)", wlog.size(), cursor_x, cursor_y);
   endtask

   task automatic test_wrap();
      int bad = 0;
      send(8'h0D);
      repeat (99) send(8'h61);
      checks++;
      if (cursor_x !== 7'd99 || cursor_y !== 5'd0) begin
         errors++;
         $display("FAIL wrap_setup_cursor: (%0d,%0d), required (99,0)", cursor_x, cursor_y);
      end
      wlog.delete();
      send(8'h5A);
      checks++;
      if (cursor_x !== 7'd0 || cursor_y !== 5'd1) begin
         errors++;
         $display("FAIL wrap_cursor: (%0d,%0d), required (0,1)", cursor_x, cursor_y);
      end
      step();
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL wrap_busy: busy=%b during row clear, required 1", busy);
      end
      wait_ready(200);
      checks++;
      if (wlog.size() != 101 || wlog[0].addr !== 12'd99 || wlog[0].data !== 8'h5A) bad++;
      for (int i = 1; i < wlog.size(); i++) begin
         if (wlog[i].addr !== 12'(99 + i) || wlog[i].data !== 8'h20 ||
             wlog[i].cyc !== wlog[1].cyc + 32'(i - 1)) bad++;
      end
      if (bad != 0) begin
         errors++;
         $display("FAIL wrap_writes: %0d writes with %0d bad, required (99,5A) then 0x20 at 100..199", wlog.size(), bad);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL wrap_busy_end: busy=%b, required 0", busy);
      end
      $display("wrap Z: %0d writes, cursor (%0d,%0d)", wlog.size(), cursor_x, cursor_y);
   endtask

   task automatic test_lf_wrap();
      int bad = 0;
      repeat (28) send(8'h0A);
      repeat (5) send(8'h62);
      checks++;
      if (cursor_x !== 7'd5 || cursor_y !== 5'd29) begin
         errors++;
         $display("FAIL lf_setup_cursor: (%0d,%0d), required (5,29)", cursor_x, cursor_y);
      end
      wlog.delete();
      send(8'h0A);
      wait_ready(200);
      checks++;
      if (cursor_x !== 7'd0 || cursor_y !== 5'd0) begin
         errors++;
         $display("FAIL lf_wrap_cursor: (%0d,%0d), required (0,0)", cursor_x, cursor_y);
      end
      checks++;
      if (wlog.size() != 100) bad++;
      foreach (wlog[i]) if (wlog[i].addr !== 12'(i) || wlog[i].data !== 8'h20) bad++;
      if (bad != 0) begin
         errors++;
         $display("FAIL lf_wrap_clear: %0d writes with %0d bad, required 0x20 at 0..99", wlog.size(), bad);
      end
      $display("LF at row 29: %0d writes, cursor (%0d,%0d)", wlog.size(), cursor_x, cursor_y);
   endtask

   task automatic test_backspace();
      send(8'h0A);
      send(8'h0A);
      repeat (3) send(8'h63);
      wait_ready(200);
      wlog.delete();
      send(8'h08);
      wait_ready(20);
      checks++;
      if (wlog.size() != 1 || wlog[0].addr !== 12'd202 || wlog[0].data !== 8'h20) begin
         errors++;
         $display("FAIL bs_write: %0d writes first=(%0d,%h), required one write (202,20)", wlog.size(),
                  (wlog.size() > 0) ? wlog[0].addr : 12'hfff, (wlog.size() > 0) ? wlog[0].data : 8'hff);
      end
      checks++;
      if (cursor_x !== 7'd2 || cursor_y !== 5'd2) begin
         errors++;
         $display("FAIL bs_cursor: (%0d,%0d), required (2,2)", cursor_x, cursor_y);
      end
      send(8'h0D);
      wait_ready(20);
      wlog.delete();
      send(8'h08);
      wait_ready(20);
      checks++;
      if (wlog.size() != 0 || cursor_x !== 7'd0 || cursor_y !== 5'd2) begin
         errors++;
         $display("FAIL bs_col0: %0d writes cursor (%0d,%0d), required 0 writes (0,2)", wlog.size(), cursor_x, cursor_y);
      end
      $display("backspace: cursor (%0d,%0d)", cursor_x, cursor_y);
   endtask

   task automatic test_discard();
      wlog.delete();
      send(8'h01);
      send(8'h7F);
      wait_ready(20);
      checks++;
      if (wlog.size() != 0 || cursor_x !== 7'd0 || cursor_y !== 5'd2 || busy !== 1'b0) begin
         errors++;
         $display("FAIL discard: %0d writes cursor (%0d,%0d) busy=%b, required 0 writes (0,2) busy 0",
                  wlog.size(), cursor_x, cursor_y, busy);
      end
      $display("discard 01,7F: %0d writes", wlog.size());
   endtask

   task automatic test_blink();
      logic prev;
      logic [31:0] tog[$];
      int bad = 0;
      int n = 0;
      prev = cursor_blink;
      for (int i = 0; i < 64; i++) begin
         step();
         if (cursor_blink !== prev) tog.push_back(cyc);
         prev = cursor_blink;
      end
      checks++;
      if (tog.size() != 4) bad++;
      for (int i = 1; i < tog.size(); i++) if (tog[i] - tog[i-1] != 32'd16) bad++;
      if (bad != 0) begin
         errors++;
         $display("FAIL blink_period: %0d toggles with %0d bad intervals, required 4 toggles 16 apart", tog.size(), bad);
      end
      while (cursor_blink !== 1'b0 && n < 40) begin
         step();
         n++;
      end
      repeat (5) step();
      send(8'h78);
      bad = 0;
      if (cursor_blink !== 1'b1) bad++;
      for (int i = 1; i < 16; i++) begin
         step();
         if (cursor_blink !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL blink_restart_hold: %0d of 16 cycles not solid, required 0", bad);
      end
      step();
      checks++;
      if (cursor_blink !== 1'b0) begin
         errors++;
         $display("FAIL blink_restart_toggle: cursor_blink=%b 16 cycles after typing, required 0", cursor_blink);
      end
      $display("blink: %0d toggles in 64 idle cycles, cursor (%0d,%0d)", tog.size(), cursor_x, cursor_y);
   endtask

   task automatic test_form_feed();
      wlog.delete();
      send(8'h0C);
      checks++;
      if (cursor_x !== 7'd0 || cursor_y !== 5'd0) begin
         errors++;
         $display("FAIL ff_cursor: (%0d,%0d), required (0,0)", cursor_x, cursor_y);
      end
      wait_ready(4000);
      check_full_clear("ff_clear_screen");
      $display("form feed: %0d clear writes", wlog.size());
   endtask

   task automatic test_reset_mid_clear();
      send(8'h0A);
      repeat (4) step();
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_clear_busy: busy=%b before reset, required 1", busy);
      end
      char_valid = 1'b1;
      char_data  = 8'h51;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_clear_reset_values");
      repeat (2) step();
      wlog.delete();
      rst_n = 1'b1;
      wait_ready(4000);
      check_full_clear("mid_clear_restart");
      step();
      char_valid = 1'b0;
      checks++;
      if ({vram_we, vram_waddr, vram_wdata, cursor_x, cursor_y} !== {1'b1, 12'd0, 8'h51, 7'd1, 5'd0}) begin
         errors++;
         $display("FAIL pending_byte: we=%b addr=%0d data=%h cursor (%0d,%0d), required 1 0 51 (1,0)",
                  vram_we, vram_waddr, vram_wdata, cursor_x, cursor_y);
      end
      $display("reset mid-clear: %0d restart writes, pending byte at cursor (%0d,%0d)", wlog.size(), cursor_x, cursor_y);
   endtask

   initial begin
      test_reset();
      test_put_ab();
      test_wrap();
      test_lf_wrap();
      test_backspace();
      test_discard();
      test_blink();
      test_form_feed();
      test_reset_mid_clear();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
